// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared FSM state type and default parameters for the pattern stream source
package pattern_pkg;

  localparam int DEPTH_DEFAULT          = 32;
  localparam int ACK_LOW_CYCLES_DEFAULT = 1;
  localparam logic [5:0] MATCH_MAX      = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_ACK_LOW,
    ST_ACK_RELEASE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/stream_buf.sv
// rtl/stream_buf.sv - byte buffer with one synchronous write port and one combinational read port
module stream_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pattern_stream_source.sv
// rtl/pattern_stream_source.sv - streams buffered bytes to a pattern detector, pausing with an ack-low
// handshake for every reported match
module pattern_stream_source
  import pattern_pkg::*;
#(
  parameter int DEPTH          = DEPTH_DEFAULT,
  parameter int ACK_LOW_CYCLES = ACK_LOW_CYCLES_DEFAULT,
  localparam int AW            = $clog2(DEPTH),
  localparam int LW            = AW + 1
) (
  input  logic          clk,
  input  logic          reset_sync,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic          start,
  input  logic [LW-1:0] stream_len,
  input  logic          found_pattern,
  output logic [7:0]    data,
  output logic          ack,
  output logic          busy,
  output logic          done,
  output logic [5:0]    match_count
);

  localparam int CW = (ACK_LOW_CYCLES > 1) ? $clog2(ACK_LOW_CYCLES) : 1;

  state_t        state;
  logic [LW-1:0] idx;
  logic [LW-1:0] len;
  logic [LW-1:0] len_clamped;
  logic [CW-1:0] ack_cnt;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  assign len_clamped = (stream_len > LW'(DEPTH)) ? LW'(DEPTH) : stream_len;
  // idx reaches DEPTH only after the last byte; pin the address rather than let it wrap
  assign rd_addr     = (idx >= LW'(DEPTH)) ? AW'(DEPTH - 1) : idx[AW-1:0];

  stream_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (load_en && !busy),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset_sync) begin
    if (!reset_sync) begin
      state       <= ST_IDLE;
      idx         <= '0;
      len         <= '0;
      ack_cnt     <= '0;
      data        <= 8'h00;
      ack         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      match_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            len         <= len_clamped;
            idx         <= '0;
            match_count <= '0;
            ack         <= 1'b1;
            if (len_clamped == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= ST_STREAM;
              done  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (found_pattern) begin
            if (match_count != MATCH_MAX) match_count <= match_count + 6'd1;
            ack     <= 1'b0;
            ack_cnt <= CW'(ACK_LOW_CYCLES - 1);
            state   <= ST_ACK_LOW;
          end else if (idx < len) begin
            data <= rd_data;
            idx  <= idx + LW'(1);
          end else begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_ACK_LOW: begin
          if (ack_cnt == '0) begin
            ack   <= 1'b1;
            state <= ST_ACK_RELEASE;
          end else begin
            ack_cnt <= ack_cnt - CW'(1);
          end
        end
        ST_ACK_RELEASE: state <= ST_STREAM;
        default:        state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_stream_source.sv
// tb/tb_pattern_stream_source.sv - self-checking bench for pattern_stream_source with two ack-low lengths
module tb_pattern_stream_source;

  logic       clk = 1'b0;
  logic       reset_sync = 1'b1;
  logic       load_en = 1'b0;
  logic [4:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic       start = 1'b0;
  logic [5:0] stream_len = '0;
  logic       fp0 = 1'b0;
  logic       fp1 = 1'b0;

  logic [7:0] o_data [2];
  logic       o_ack  [2];
  logic       o_busy [2];
  logic       o_done [2];
  logic [5:0] o_mc   [2];

  int checks = 0;
  int failures = 0;

  // reference model: mode 0 idle, 1 running, 2 done; wait counts remaining handshake cycles
  int         m_mode [2];
  int         m_pos  [2];
  int         m_len  [2];
  int         m_wait [2];
  int         m_mc   [2];
  logic [7:0] m_data [2];
  logic [7:0] m_buf  [2][32];

  always #5 clk = ~clk;

  pattern_stream_source #(.DEPTH(32), .ACK_LOW_CYCLES(1)) dut (
    .clk(clk), .reset_sync(reset_sync), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stream_len(stream_len), .found_pattern(fp0),
    .data(o_data[0]), .ack(o_ack[0]), .busy(o_busy[0]), .done(o_done[0]), .match_count(o_mc[0])
  );

  pattern_stream_source #(.DEPTH(32), .ACK_LOW_CYCLES(3)) dut3 (
    .clk(clk), .reset_sync(reset_sync), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stream_len(stream_len), .found_pattern(fp1),
    .data(o_data[1]), .ack(o_ack[1]), .busy(o_busy[1]), .done(o_done[1]), .match_count(o_mc[1])
  );

  function automatic int low_cycles(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_pos[i] = 0; m_len[i] = 0; m_wait[i] = 0; m_mc[i] = 0; m_data[i] = 8'h00;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic fp;
      fp = (i == 0) ? fp0 : fp1;
      if (load_en && m_mode[i] != 1) m_buf[i][load_addr] = load_data;
      if (m_mode[i] != 1) begin
        if (start) begin
          m_len[i]  = (stream_len > 6'd32) ? 32 : int'(stream_len);
          m_pos[i]  = 0;
          m_mc[i]   = 0;
          m_wait[i] = 0;
          m_mode[i] = (m_len[i] == 0) ? 2 : 1;
        end
      end else if (m_wait[i] > 0) begin
        m_wait[i]--;
      end else if (fp) begin
        if (m_mc[i] < 63) m_mc[i]++;
        m_wait[i] = low_cycles(i) + 1;
      end else if (m_pos[i] < m_len[i]) begin
        m_data[i] = m_buf[i][m_pos[i]];
        m_pos[i]++;
      end else begin
        m_mode[i] = 2;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic exp_ack;
      exp_ack = (m_mode[i] == 0) ? 1'b0 : (m_wait[i] > 1) ? 1'b0 : 1'b1;
      chk($sformatf("data%0d", i), 32'(o_data[i]), 32'(m_data[i]));
      chk($sformatf("ack%0d", i), 32'(o_ack[i]), 32'(exp_ack));
      chk($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(m_mode[i] == 1));
      chk($sformatf("done%0d", i), 32'(o_done[i]), 32'(m_mode[i] == 2));
      chk($sformatf("mc%0d", i), 32'(o_mc[i]), 32'(m_mc[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_sync) model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_start(input logic [5:0] l);
    start = 1'b1;
    stream_len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd_fp);
    int n;
    n = 0;
    while (!(o_done[0] && o_done[1]) && n < budget) begin
      if (rnd_fp) begin
        fp0 = ($urandom_range(0, 7) == 0);
        fp1 = ($urandom_range(0, 7) == 0);
      end
      tick();
      n++;
    end
    fp0 = 1'b0;
    fp1 = 1'b0;
    chk("run_done0", 32'(o_done[0]), 32'd1);
    chk("run_done1", 32'(o_done[1]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] last0;
    model_reset();
    for (int i = 0; i < 2; i++) for (int a = 0; a < 32; a++) m_buf[i][a] = 8'h00;

    // reset state
    #2 reset_sync = 1'b0;
    #1 compare_all();
    tick();
    tick();
    reset_sync = 1'b1;
    tick();

    // load 00..1F and stream the full buffer
    load_en = 1'b1;
    for (int a = 0; a < 32; a++) begin
      load_addr = 5'(a);
      load_data = 8'(a);
      tick();
    end
    load_en = 1'b0;
    do_start(6'd32);
    for (int c = 0; c < 32; c++) tick();
    chk("done_before_33", 32'(o_done[0]), 32'd0);
    tick();
    chk("done_at_33", 32'(o_done[0]), 32'd1);
    chk("data_last", 32'(o_data[0]), 32'h1f);
    chk("mc_zero", 32'(o_mc[0]), 32'd0);

    // single match on byte 05
    do_start(6'd32);
    n = 0;
    while (o_data[0] !== 8'h05 && n < 100) begin tick(); n++; end
    chk("saw_05", 32'(o_data[0]), 32'h05);
    fp0 = 1'b1;
    tick();
    fp0 = 1'b0;
    chk("m05_ack_low", 32'(o_ack[0]), 32'd0);
    chk("m05_hold", 32'(o_data[0]), 32'h05);
    tick();
    chk("m05_ack_rel", 32'(o_ack[0]), 32'd1);
    tick();
    chk("m05_hold2", 32'(o_data[0]), 32'h05);
    tick();
    chk("m05_next", 32'(o_data[0]), 32'h06);
    chk("m05_mc", 32'(o_mc[0]), 32'd1);
    wait_done(200, 1'b0);

    // three-cycle ack on the last byte of a short run
    load_en = 1'b1; load_addr = 5'd3; load_data = 8'hAA;
    tick();
    load_en = 1'b0;
    do_start(6'd4);
    n = 0;
    while (o_data[1] !== 8'hAA && n < 50) begin tick(); n++; end
    chk("saw_aa", 32'(o_data[1]), 32'haa);
    fp1 = 1'b1;
    tick();
    fp1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("aa_ack_low_%0d", c), 32'(o_ack[1]), 32'd0);
      tick();
    end
    chk("aa_ack_rel", 32'(o_ack[1]), 32'd1);
    chk("aa_not_done", 32'(o_done[1]), 32'd0);
    wait_done(50, 1'b0);
    chk("aa_data", 32'(o_data[1]), 32'haa);
    chk("aa_mc", 32'(o_mc[1]), 32'd1);

    // reset in the middle of ACK_LOW, then replay
    do_start(6'd32);
    tick(); tick(); tick();
    fp1 = 1'b1;
    tick();
    fp1 = 1'b0;
    tick();
    chk("pre_rst_ack_low", 32'(o_ack[1]), 32'd0);
    #2 reset_sync = 1'b0;
    model_reset();
    #1 compare_all();
    chk("rst_data", 32'(o_data[1]), 32'h00);
    chk("rst_busy", 32'(o_busy[1]), 32'd0);
    tick();
    reset_sync = 1'b1;
    tick();
    do_start(6'd32);
    tick();
    chk("replay_b0", 32'(o_data[0]), 32'h00);
    tick();
    chk("replay_b1", 32'(o_data[0]), 32'h01);
    wait_done(200, 1'b0);

    // writes and starts while busy are ignored
    do_start(6'd8);
    tick();
    load_en = 1'b1; load_addr = 5'd3; load_data = 8'hFF;
    start = 1'b1; stream_len = 6'd2;
    tick();
    load_en = 1'b0; start = 1'b0;
    wait_done(50, 1'b0);
    chk("ign_last", 32'(o_data[0]), 32'h07);
    do_start(6'd4);
    wait_done(50, 1'b0);
    chk("ign_b3", 32'(o_data[0]), 32'haa);

    // zero length goes straight to DONE
    do_start(6'd0);
    chk("len0_done", 32'(o_done[0]), 32'd1);
    chk("len0_busy", 32'(o_busy[0]), 32'd0);
    chk("len0_data", 32'(o_data[0]), 32'haa);
    tick();

    // match_count saturation with found_pattern held high
    do_start(6'd32);
    fp0 = 1'b1;
    for (int c = 0; c < 210; c++) tick();
    chk("sat_mc", 32'(o_mc[0]), 32'd63);
    fp0 = 1'b0;
    wait_done(100, 1'b0);

    // randomized runs: random contents, lengths (including clamped), matches, busy writes and starts
    for (int r = 0; r < 8; r++) begin
      load_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
        load_addr = 5'($urandom_range(0, 31));
        load_data = 8'($urandom);
        tick();
      end
      load_en = 1'b0;
      do_start(6'($urandom_range(0, 63)));
      for (int c = 0; c < 10; c++) begin
        fp0 = ($urandom_range(0, 5) == 0);
        fp1 = ($urandom_range(0, 5) == 0);
        load_en = $urandom_range(0, 1);
        load_addr = 5'($urandom_range(0, 31));
        load_data = 8'($urandom);
        start = ($urandom_range(0, 3) == 0);
        stream_len = 6'($urandom_range(0, 63));
        tick();
      end
      load_en = 1'b0;
      start = 1'b0;
      wait_done(400, 1'b1);
      tick();
    end

    last0 = o_data[0];
    chk("final_hold", 32'(o_data[0]), 32'(last0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
